// File: rtl/post_spike_aer_encoder_pkg.sv
// Shared definitions for the post-neuron spike AER encoder: serializer state
// encoding, default sizes and the FIFO entry layout.
package post_spike_aer_encoder_pkg;

    typedef logic [1:0] enc_state_t;

    localparam enc_state_t ST_IDLE   = 2'd0;
    localparam enc_state_t ST_LOAD   = 2'd1;
    localparam enc_state_t ST_REQ_HI = 2'd2;
    localparam enc_state_t ST_REQ_LO = 2'd3;

    localparam int unsigned AER_WIDTH_DEFAULT  = 12;
    localparam int unsigned FIFO_DEPTH_DEFAULT = 8;

    // Entry = {lane-0 address with lane bits cleared, per-lane spike mask}
    function automatic int unsigned fifo_entry_width(input int unsigned addr_width,
                                                     input int unsigned lanes);
        return addr_width + lanes;
    endfunction

endpackage

// File: rtl/post_spike_aer_encoder_fifo.sv
// Synchronous spike-word FIFO with first-word-fall-through read port.
// DEPTH must be a power of two so the pointers wrap naturally.
module spike_word_fifo #(
    parameter int unsigned WIDTH = 14,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    // A write while full is accepted only when the head leaves in the same cycle
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_rd) rd_ptr <= rd_ptr + PTR_W'(1);
            if (do_wr && !do_rd)      count <= count + (PTR_W+1)'(1);
            else if (!do_wr && do_rd) count <= count - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/post_spike_aer_encoder.sv
// Buffers per-word spike masks from the neuron core and serializes each set
// lane as one four-phase AER address event, lowest lane first.
module post_spike_aer_encoder
    import post_spike_aer_encoder_pkg::*;
#(
    parameter int unsigned POST_NEUR_PARALLEL   = 4,
    parameter int unsigned POST_NEUR_ADDR_WIDTH = 10,
    parameter int unsigned AER_WIDTH            = AER_WIDTH_DEFAULT,
    parameter int unsigned FIFO_DEPTH           = FIFO_DEPTH_DEFAULT
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [POST_NEUR_PARALLEL-1:0]   NEUR_EVENT_IN,
    input  logic                            NEUR_EVENT_VALID,
    input  logic [POST_NEUR_ADDR_WIDTH-1:0] CTRL_POST_NEURON_ADDRESS,
    output logic [AER_WIDTH-1:0]            AEROUT_ADDR,
    output logic                            AEROUT_REQ,
    input  logic                            AEROUT_ACK,
    output logic                            ENC_FULL,
    output logic                            ENC_BUSY,
    output logic                            ENC_OVF
);

    localparam int unsigned LANE_SHIFT = $clog2(POST_NEUR_PARALLEL);
    localparam int unsigned LANE_W     = (LANE_SHIFT > 0) ? LANE_SHIFT : 1;
    localparam int unsigned ENTRY_W    = fifo_entry_width(POST_NEUR_ADDR_WIDTH, POST_NEUR_PARALLEL);
    localparam logic [POST_NEUR_PARALLEL-1:0] MASK_ONE = POST_NEUR_PARALLEL'(1);

    enc_state_t                      state;
    logic                            ack_meta;
    logic                            ack_sync;
    logic [POST_NEUR_ADDR_WIDTH-1:0] work_addr;
    logic [POST_NEUR_PARALLEL-1:0]   work_mask;
    logic [POST_NEUR_ADDR_WIDTH-1:0] word_base;
    logic [POST_NEUR_ADDR_WIDTH-1:0] neuron_index;
    logic [LANE_W-1:0]               lane;
    logic [ENTRY_W-1:0]              fifo_rd_data;
    logic                            fifo_full;
    logic                            fifo_empty;
    logic                            has_spikes;
    logic                            push;
    logic                            pop;

    assign word_base  = (CTRL_POST_NEURON_ADDRESS >> LANE_SHIFT) << LANE_SHIFT;
    assign has_spikes = |NEUR_EVENT_IN;

    // Pop on the way out of IDLE, or when the handshake closes with the working word exhausted
    assign pop = !fifo_empty &&
                 ((state == ST_IDLE) ||
                  (state == ST_REQ_LO && !ack_sync && work_mask == '0));
    assign push = NEUR_EVENT_VALID && has_spikes && (!fifo_full || pop);

    assign ENC_FULL = fifo_full;
    assign ENC_BUSY = !fifo_empty || (state != ST_IDLE);

    spike_word_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (CLK),
        .rst    (RST),
        .wr_en  (push),
        .wr_data({word_base, NEUR_EVENT_IN}),
        .rd_en  (pop),
        .rd_data(fifo_rd_data),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    always_comb begin
        lane = '0;
        for (int unsigned i = POST_NEUR_PARALLEL; i > 0; i--) begin
            if (work_mask[i-1]) lane = LANE_W'(i-1);
        end
    end

    assign neuron_index = work_addr + POST_NEUR_ADDR_WIDTH'(lane);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ack_meta <= 1'b0;
            ack_sync <= 1'b0;
        end else begin
            ack_meta <= AEROUT_ACK;
            ack_sync <= ack_meta;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ENC_OVF <= 1'b0;
        end else if (NEUR_EVENT_VALID && has_spikes && fifo_full && !pop) begin
            ENC_OVF <= 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= ST_IDLE;
            work_addr   <= '0;
            work_mask   <= '0;
            AEROUT_REQ  <= 1'b0;
            AEROUT_ADDR <= '0;
        end else begin
            if (pop) begin
                work_addr <= fifo_rd_data[ENTRY_W-1:POST_NEUR_PARALLEL];
                work_mask <= fifo_rd_data[POST_NEUR_PARALLEL-1:0];
            end
            case (state)
                ST_IDLE: begin
                    if (pop) state <= ST_LOAD;
                end
                // Holding off until the synchronized ACK is low also covers ACK stuck high after reset
                ST_LOAD: begin
                    if (!ack_sync) begin
                        AEROUT_ADDR <= AER_WIDTH'(neuron_index);
                        AEROUT_REQ  <= 1'b1;
                        state       <= ST_REQ_HI;
                    end
                end
                ST_REQ_HI: begin
                    if (ack_sync) begin
                        AEROUT_REQ <= 1'b0;
                        work_mask  <= work_mask & (work_mask - MASK_ONE);
                        state      <= ST_REQ_LO;
                    end
                end
                ST_REQ_LO: begin
                    if (!ack_sync) begin
                        if (work_mask != '0 || pop) state <= ST_LOAD;
                        else                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_post_spike_aer_encoder.sv
// Self-checking bench for post_spike_aer_encoder: directed vectors, handshake
// corner cases and randomized traffic against an address-list reference model.
module tb_post_spike_aer_encoder;

    localparam int PAR   = 4;
    localparam int AW    = 10;
    localparam int XW    = 12;
    localparam int DEPTH = 8;

    logic          CLK = 1'b0;
    logic          rst;
    logic [PAR-1:0] ev;
    logic          valid;
    logic [AW-1:0] caddr;
    logic [XW-1:0] aer_addr;
    logic          req;
    logic          ack;
    logic          full;
    logic          busy;
    logic          ovf;

    always #5 CLK = ~CLK;

    post_spike_aer_encoder #(
        .POST_NEUR_PARALLEL  (PAR),
        .POST_NEUR_ADDR_WIDTH(AW),
        .AER_WIDTH           (XW),
        .FIFO_DEPTH          (DEPTH)
    ) dut (
        .CLK                     (CLK),
        .RST                     (rst),
        .NEUR_EVENT_IN           (ev),
        .NEUR_EVENT_VALID        (valid),
        .CTRL_POST_NEURON_ADDRESS(caddr),
        .AEROUT_ADDR             (aer_addr),
        .AEROUT_REQ              (req),
        .AEROUT_ACK              (ack),
        .ENC_FULL                (full),
        .ENC_BUSY                (busy),
        .ENC_OVF                 (ovf)
    );

    int checks = 0;
    int errors = 0;
    logic [XW-1:0] got[$];
    logic [XW-1:0] expq[$];
    bit auto_ack = 1'b0;
    int ack_delay = 3;

    typedef struct {
        logic [AW-1:0]  addr;
        logic [PAR-1:0] mask;
        int             n;
        logic [XW-1:0]  evs[4];
    } vec_t;
    vec_t tbl[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic send_word(input logic [AW-1:0] a, input logic [PAR-1:0] m);
        valid = 1'b1;
        caddr = a;
        ev    = m;
        tick();
        valid = 1'b0;
        ev    = '0;
    endtask

    // Reference: every set lane becomes (lane-0 address + lane) mod 2^AW, ascending lane order
    function automatic void model_word(input logic [AW-1:0] a, input logic [PAR-1:0] m);
        int unsigned base;
        base = (int'(a) / PAR) * PAR;
        for (int l = 0; l < PAR; l++)
            if (m[l]) expq.push_back(XW'((base + l) % (1 << AW)));
    endfunction

    task automatic wait_req(input string name, input logic level);
        for (int i = 0; i < 200 && req !== level; i++) tick();
        check(name, req, level);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 2000 && (busy || req || ack); i++) tick();
        check(name, {busy, req, ack}, 3'b000);
    endtask

    task automatic compare_queues(input string name);
        check({name, "_count"}, got.size(), expq.size());
        for (int i = 0; i < got.size() && i < expq.size(); i++)
            check($sformatf("%s_ev%0d", name, i), got[i], expq[i]);
    endtask

    task automatic do_reset;
        rst = 1'b1;
        valid = 1'b0;
        ev = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        got.delete();
        expq.delete();
    endtask

    task automatic set_vec(input int i, input logic [AW-1:0] a, input logic [PAR-1:0] m, input int n,
                           input logic [XW-1:0] e0, input logic [XW-1:0] e1,
                           input logic [XW-1:0] e2, input logic [XW-1:0] e3);
        tbl[i].addr = a;
        tbl[i].mask = m;
        tbl[i].n    = n;
        tbl[i].evs[0] = e0;
        tbl[i].evs[1] = e1;
        tbl[i].evs[2] = e2;
        tbl[i].evs[3] = e3;
    endtask

    // Records each request rise and checks the address holds while REQ is high
    initial begin
        logic prev;
        logic [XW-1:0] held;
        prev = 1'b0;
        held = '0;
        forever begin
            @(negedge CLK);
            if (rst) begin
                prev = 1'b0;
            end else begin
                if (req && !prev) begin
                    got.push_back(aer_addr);
                    held = aer_addr;
                end else if (req && prev) begin
                    check("addr_stable", aer_addr, held);
                end
                prev = req;
            end
        end
    end

    // Four-phase receiver: follows REQ after ack_delay cycles when enabled
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(posedge CLK);
            #2;
            if (auto_ack) begin
                if (req !== ack) begin
                    cnt++;
                    if (cnt >= ack_delay) begin
                        ack = req;
                        cnt = 0;
                    end
                end else begin
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0]  ra;
        logic [PAR-1:0] rm;

        rst = 1'b1;
        valid = 1'b0;
        ev = '0;
        caddr = '0;
        ack = 1'b0;

        set_vec(0, 10'h014, 4'b0100, 1, 12'h016, 12'h000, 12'h000, 12'h000);
        set_vec(1, 10'h3FC, 4'b1011, 3, 12'h3FC, 12'h3FD, 12'h3FF, 12'h000);
        set_vec(2, 10'h3FF, 4'b1111, 4, 12'h3FC, 12'h3FD, 12'h3FE, 12'h3FF);
        set_vec(3, 10'h005, 4'b0001, 1, 12'h004, 12'h000, 12'h000, 12'h000);
        set_vec(4, 10'h000, 4'b1000, 1, 12'h003, 12'h000, 12'h000, 12'h000);
        set_vec(5, 10'h123, 4'b0000, 0, 12'h000, 12'h000, 12'h000, 12'h000);
        set_vec(6, 10'h2A3, 4'b0110, 2, 12'h2A1, 12'h2A2, 12'h000, 12'h000);
        set_vec(7, 10'h0FE, 4'b1001, 2, 12'h0FC, 12'h0FF, 12'h000, 12'h000);

        tick();
        tick();
        check("rst_req", req, 1'b0);
        check("rst_addr", aer_addr, 12'h000);
        check("rst_full", full, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ovf", ovf, 1'b0);
        rst = 1'b0;
        tick();
        tick();

        // Single spike latency: VALID sampled at edge k, REQ visible after edge k+2
        auto_ack = 1'b1;
        ack_delay = 3;
        got.delete();
        expq.delete();
        expq.push_back(12'h016);
        send_word(10'h014, 4'b0100);
        check("lat_k_req", req, 1'b0);
        check("lat_k_busy", busy, 1'b1);
        tick();
        check("lat_k1_req", req, 1'b0);
        tick();
        check("lat_k2_req", req, 1'b1);
        check("lat_k2_addr", aer_addr, 12'h016);
        wait_idle("lat_idle");
        compare_queues("lat");

        for (int v = 0; v < 8; v++) begin
            got.delete();
            expq.delete();
            for (int e = 0; e < tbl[v].n; e++) expq.push_back(tbl[v].evs[e]);
            send_word(tbl[v].addr, tbl[v].mask);
            wait_idle($sformatf("vec%0d_idle", v));
            compare_queues($sformatf("vec%0d", v));
            check($sformatf("vec%0d_busy", v), busy, 1'b0);
        end

        // Zero mask never occupies the encoder
        send_word(10'h040, 4'b0000);
        check("zero_busy0", busy, 1'b0);
        tick();
        check("zero_busy1", busy, 1'b0);
        check("zero_req", req, 1'b0);

        // Randomized traffic, controller honours ENC_FULL
        do_reset();
        auto_ack = 1'b1;
        for (int n = 0; n < 400; n++) begin
            ack_delay = $urandom_range(1, 4);
            if (!full && $urandom_range(0, 2) != 0) begin
                ra = AW'($urandom);
                rm = PAR'($urandom);
                if ($urandom_range(0, 7) == 0) rm = '0;
                model_word(ra, rm);
                send_word(ra, rm);
            end else begin
                tick();
            end
        end
        wait_idle("rnd_idle");
        compare_queues("rnd");
        check("rnd_ovf", ovf, 1'b0);

        // Push and pop in the same cycle while full
        do_reset();
        auto_ack = 1'b0;
        ack_delay = 3;
        ack = 1'b0;
        model_word(10'h100, 4'b0001);
        send_word(10'h100, 4'b0001);
        wait_req("pp_w0_req", 1'b1);
        for (int i = 1; i <= 8; i++) begin
            model_word(AW'(10'h200 + 4 * i), PAR'(i));
            send_word(AW'(10'h200 + 4 * i), PAR'(i));
            if (i == 7) check("pp_full_at7", full, 1'b0);
        end
        check("pp_full_at8", full, 1'b1);
        check("pp_ovf_at8", ovf, 1'b0);
        ack = 1'b1;
        wait_req("pp_req_drop", 1'b0);
        ack = 1'b0;
        tick();
        tick();
        model_word(10'h3A0, 4'b0101);
        send_word(10'h3A0, 4'b0101);
        check("pp_full_after", full, 1'b1);
        check("pp_ovf_after", ovf, 1'b0);
        tick();
        check("pp_next_req", req, 1'b1);
        auto_ack = 1'b1;
        wait_idle("pp_idle");
        compare_queues("pp");
        check("pp_ovf_end", ovf, 1'b0);

        // Overflow with the serializer stalled on ACK low
        do_reset();
        auto_ack = 1'b0;
        ack = 1'b0;
        model_word(10'h010, 4'b0011);
        send_word(10'h010, 4'b0011);
        wait_req("ovf_w0_req", 1'b1);
        for (int i = 1; i <= 9; i++) begin
            if (i <= 8) model_word(AW'(10'h040 + 4 * i), PAR'(i + 1));
            send_word(AW'(10'h040 + 4 * i), PAR'(i + 1));
            if (i == 7) check("ovf_full_at7", full, 1'b0);
            if (i == 8) begin
                check("ovf_full_at8", full, 1'b1);
                check("ovf_flag_at8", ovf, 1'b0);
            end
        end
        check("ovf_flag_at9", ovf, 1'b1);
        check("ovf_full_at9", full, 1'b1);
        auto_ack = 1'b1;
        wait_idle("ovf_idle");
        compare_queues("ovf");
        check("ovf_sticky", ovf, 1'b1);
        do_reset();
        check("ovf_cleared", ovf, 1'b0);

        // Reset in the middle of a handshake, ACK still high afterwards
        auto_ack = 1'b0;
        ack = 1'b0;
        send_word(10'h080, 4'b0001);
        wait_req("mid_req", 1'b1);
        got.delete();
        expq.delete();
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_req", req, 1'b0);
        check("mid_rst_addr", aer_addr, 12'h000);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_full", full, 1'b0);
        ack = 1'b1;
        @(posedge CLK);
        #1;
        rst = 1'b0;
        tick();
        tick();
        tick();
        model_word(10'h0C4, 4'b0010);
        send_word(10'h0C4, 4'b0010);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("mid_hold%0d", i), req, 1'b0);
            tick();
        end
        ack = 1'b0;
        wait_req("mid_after_ack_low", 1'b1);
        check("mid_addr", aer_addr, 12'h0C5);
        auto_ack = 1'b1;
        wait_idle("mid_idle");
        compare_queues("mid");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
